// File: rtl/xadc_drp_scheduler.sv
// Round-robin DRP read sequencer for up to four XADC auxiliary channels, triggered by eoc.
// Optional macro DRP_TIMEOUT_EN bounds each DRP wait and reports abandoned reads on timeout_err.
module xadc_drp_scheduler #(
    parameter int         NUM_CH  = 2,
    parameter logic [6:0] ADDR0   = 7'h13,
    parameter logic [6:0] ADDR1   = 7'h1B,
    parameter logic [6:0] ADDR2   = 7'h12,
    parameter logic [6:0] ADDR3   = 7'h1A,
    parameter int         TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  ch_enable,
    input  logic        eoc,
    input  logic        drdy,
    input  logic [15:0] do_in,
    output logic        den,
    output logic        dwe,
    output logic [6:0]  daddr,
    output logic [11:0] sample,
    output logic [1:0]  sample_ch,
    output logic        sample_valid,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err,
    input  logic        clear_flags
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

    localparam logic [3:0] CH_LIMIT = 4'((1 << NUM_CH) - 1);

    state_t     state, state_nxt;
    logic [3:0] ch_mask, mask_q;
    logic [1:0] slot, slot_nxt;
    logic [2:0] next_slot;
    logic       pending, start, load_req, capture, tmo_hit;
    logic       unused_do_lsbs;

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) r = 2'(i);
        return r;
    endfunction

    // Returns {found, index} of the lowest set bit strictly above s.
    function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] s);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i] && (i > int'(s))) r = {1'b1, 2'(i)};
        return r;
    endfunction

    function automatic logic [6:0] slot_addr(input logic [1:0] s);
        case (s)
            2'd0:    return ADDR0;
            2'd1:    return ADDR1;
            2'd2:    return ADDR2;
            default: return ADDR3;
        endcase
    endfunction

    assign ch_mask        = ch_enable & CH_LIMIT;
    assign start          = (eoc || pending) && (ch_mask != 4'd0);
    assign next_slot      = next_above(mask_q, slot);
    assign unused_do_lsbs = ^do_in[3:0];

    assign den          = (state == REQ);
    assign dwe          = 1'b0;
    assign sample_valid = (state == OUT);
    assign busy         = (state != IDLE);

`ifdef DRP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wait_cnt <= '0;
        else if (state != WAIT)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            timeout_err <= 1'b0;
        else
            timeout_err <= (timeout_err && !clear_flags) || tmo_hit;
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        load_req  = 1'b0;
        capture   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = REQ;
                    slot_nxt  = lowest_set(ch_mask);
                    load_req  = 1'b1;
                end
            end
            REQ:  state_nxt = WAIT;
            WAIT: begin
                if (drdy) begin
                    capture   = 1'b1;
                    state_nxt = OUT;
                end
`ifdef DRP_TIMEOUT_EN
                else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                    tmo_hit = 1'b1;
                    if (next_slot[2]) begin
                        slot_nxt  = next_slot[1:0];
                        load_req  = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
`endif
            end
            default: begin
                if (next_slot[2]) begin
                    slot_nxt  = next_slot[1:0];
                    load_req  = 1'b1;
                    state_nxt = REQ;
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            slot      <= 2'd0;
            mask_q    <= 4'd0;
            daddr     <= 7'd0;
            sample    <= 12'd0;
            sample_ch <= 2'd0;
            pending   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
            if (state == IDLE && start)
                mask_q <= ch_mask;
            if (load_req)
                daddr <= slot_addr(slot_nxt);
            if (capture) begin
                sample    <= do_in[15:4];
                sample_ch <= slot;
            end
            // eoc during a scan: first one is queued, a second one is an overrun.
            if (state == IDLE && start)
                pending <= 1'b0;
            else if (state != IDLE && eoc)
                pending <= 1'b1;
            overrun <= (overrun && !clear_flags) || (state != IDLE && eoc && pending);
        end
    end

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Scoreboard bench for xadc_drp_scheduler: directed scans with a simple DRP responder model.
module tb_xadc_drp_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  ch_enable = 4'd0;
    logic        eoc = 1'b0;
    logic        drdy = 1'b0;
    logic [15:0] do_in = 16'd0;
    logic        clear_flags = 1'b0;
    logic        den, dwe, sample_valid, busy, overrun, timeout_err;
    logic [6:0]  daddr;
    logic [11:0] sample;
    logic [1:0]  sample_ch;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0]  exp_addr[$];
    logic [13:0] exp_smp[$];
    logic [15:0] drp_data[$];
    bit          resp_en = 1'b1;

    xadc_drp_scheduler dut (
        .clk(clk), .reset_n(reset_n), .ch_enable(ch_enable), .eoc(eoc),
        .drdy(drdy), .do_in(do_in), .den(den), .dwe(dwe), .daddr(daddr),
        .sample(sample), .sample_ch(sample_ch), .sample_valid(sample_valid),
        .busy(busy), .overrun(overrun), .timeout_err(timeout_err),
        .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_eoc();
        cyc(1);
        eoc = 1'b1;
        cyc(1);
        eoc = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) return;
            cyc(1);
        end
        check("idle_budget", busy, 1'b0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_addr_q"}, exp_addr.size(), 0);
        check({tag, "_smp_q"}, exp_smp.size(), 0);
    endtask

    // DRP responder: answers each den three cycles later with the next queued word.
    initial begin
        forever begin
            @(negedge clk);
            if (den && resp_en && drp_data.size() > 0) begin
                repeat (3) @(posedge clk);
                #1;
                drdy  = 1'b1;
                do_in = drp_data.pop_front();
                @(posedge clk);
                #1;
                drdy = 1'b0;
            end
        end
    end

    // Monitor: every den and every sample strobe is matched against the scoreboard.
    initial begin
        logic [13:0] e;
        forever begin
            @(negedge clk);
            if (den) begin
                if (exp_addr.size() == 0) check("den_unexpected", 1'b1, 1'b0);
                else begin
                    check("daddr", daddr, exp_addr.pop_front());
                    check("dwe", dwe, 1'b0);
                end
            end
            if (sample_valid) begin
                if (exp_smp.size() == 0) check("strobe_unexpected", 1'b1, 1'b0);
                else begin
                    e = exp_smp.pop_front();
                    check("sample", sample, e[11:0]);
                    check("sample_ch", sample_ch, e[13:12]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(3);
        check("rst_den", den, 0);
        check("rst_busy", busy, 0);
        check("rst_daddr", daddr, 0);
        check("rst_sample", sample, 0);
        check("rst_sample_ch", sample_ch, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout_err, 0);
        reset_n = 1'b1;
        cyc(2);

        // Two-slot scan with latency check on the first den
        ch_enable = 4'b0011;
        exp_addr.push_back(7'h13); exp_addr.push_back(7'h1B);
        drp_data.push_back(16'hABC0); drp_data.push_back(16'h1230);
        exp_smp.push_back({2'd0, 12'hABC}); exp_smp.push_back({2'd1, 12'h123});
        pulse_eoc();
        check("lat_den", den, 1);
        check("lat_daddr", daddr, 7'h13);
        wait_idle(60);
        check_drained("scan2");
        check("hold_sample", sample, 12'h123);
        check("hold_ch", sample_ch, 1);

        // Single enabled slot 1
        ch_enable = 4'b0010;
        exp_addr.push_back(7'h1B);
        drp_data.push_back(16'h5675);
        exp_smp.push_back({2'd1, 12'h567});
        pulse_eoc();
        wait_idle(60);
        check_drained("slot1");

        // Empty mask: eoc ignored
        ch_enable = 4'b0000;
        pulse_eoc();
        cyc(8);
        check("empty_busy", busy, 0);
        check("empty_overrun", overrun, 0);

        // Pending + overrun: two extra eocs during a scan
        ch_enable = 4'b0011;
        for (int s = 0; s < 2; s++) begin
            exp_addr.push_back(7'h13); exp_addr.push_back(7'h1B);
        end
        drp_data.push_back(16'h1110); drp_data.push_back(16'h2220);
        drp_data.push_back(16'h3330); drp_data.push_back(16'h4440);
        exp_smp.push_back({2'd0, 12'h111}); exp_smp.push_back({2'd1, 12'h222});
        exp_smp.push_back({2'd0, 12'h333}); exp_smp.push_back({2'd1, 12'h444});
        pulse_eoc();
        pulse_eoc();
        check("pend_no_ovr", overrun, 0);
        pulse_eoc();
        check("overrun_set", overrun, 1);
        wait_idle(60);
        check("gap_idle", busy, 0);
        cyc(1);
        check("rescan_start", busy, 1);
        check("rescan_den", den, 1);
        wait_idle(60);
        check_drained("pend");
        clear_flags = 1'b1;
        cyc(1);
        clear_flags = 1'b0;
        check("overrun_clr", overrun, 0);

        // Reset while waiting on drdy; a late drdy must be ignored
        ch_enable = 4'b0001;
        resp_en = 1'b0;
        exp_addr.push_back(7'h13);
        pulse_eoc();
        cyc(3);
        reset_n = 1'b0;
        cyc(1);
        check("rstw_busy", busy, 0);
        check("rstw_daddr", daddr, 0);
        check("rstw_valid", sample_valid, 0);
        drdy = 1'b1; do_in = 16'hDEA0;
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
        drdy = 1'b0;
        cyc(3);
        check("rstw_idle", busy, 0);
        check("rstw_sample", sample, 0);
        resp_en = 1'b1;
        exp_addr.push_back(7'h13);
        drp_data.push_back(16'h0FF0);
        exp_smp.push_back({2'd0, 12'h0FF});
        pulse_eoc();
        wait_idle(60);
        check_drained("rstw");

        // Mask change mid-scan only affects the next scan
        ch_enable = 4'b0011;
        exp_addr.push_back(7'h13); exp_addr.push_back(7'h1B); exp_addr.push_back(7'h13);
        drp_data.push_back(16'hA010); drp_data.push_back(16'hB020); drp_data.push_back(16'hC030);
        exp_smp.push_back({2'd0, 12'hA01}); exp_smp.push_back({2'd1, 12'hB02});
        exp_smp.push_back({2'd0, 12'hC03});
        pulse_eoc();
        cyc(2);
        ch_enable = 4'b0001;
        wait_idle(60);
        pulse_eoc();
        wait_idle(60);
        check_drained("mask");

`ifndef DRP_TIMEOUT_EN
        check("timeout_tied", timeout_err, 0);
`endif
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xadc_drp_scheduler.md
Name: xadc_drp_scheduler

Overview:
- Sequences DRP reads of the XADC for up to four analog auxiliary channels after every end-of-conversion pulse.
- Shares the single DRP port round-robin among enabled channels.
- Delivers tagged 12-bit samples to the oversample and pwm stages.
- Sits between the xadc_guitar instance and the per-channel oversample16/oversample256 instances, replacing the constant den/daddr tie-offs.

Parameters:
- NUM_CH, 2, number of channel slots scanned (1..4)
- ADDR0, 7'h13, DRP address of slot 0 (VAUX3)
- ADDR1, 7'h1B, DRP address of slot 1 (VAUX11)
- ADDR2, 7'h12, DRP address of slot 2 (VAUX2)
- ADDR3, 7'h1A, DRP address of slot 3 (VAUX10)
- TIMEOUT, 63, max cycles waiting for drdy before abandoning a read (DRP_TIMEOUT_EN only)

Ports:
- clk  in  1  system clock (clk_104mhz domain)
- reset_n  in  1  asynchronous active-low reset
- ch_enable  in  4  per-slot enable mask; bits >= NUM_CH ignored
- eoc  in  1  XADC end-of-conversion pulse
- drdy  in  1  XADC DRP data ready
- do_in  in  16  XADC DRP read data
- den  out  1  DRP enable, one-cycle pulse per read
- dwe  out  1  DRP write enable, constant 0
- daddr  out  7  DRP address, valid while den high
- sample  out  12  do_in[15:4] of the completed read
- sample_ch  out  2  slot index of sample
- sample_valid  out  1  one-cycle strobe for sample/sample_ch
- busy  out  1  high whenever state != IDLE
- overrun  out  1  sticky; eoc arrived while a scan was running and one was already pending
- timeout_err  out  1  sticky; a read was abandoned (DRP_TIMEOUT_EN only, else 0)
- clear_flags  in  1  synchronous clear of overrun and timeout_err

Behaviour:
- Reset: state IDLE; den=0, dwe=0, daddr=0, sample=0, sample_ch=0, sample_valid=0, busy=0, overrun=0, timeout_err=0, pending=0, slot=0. Reset mid-read aborts immediately; a late drdy after reset is ignored in IDLE.
- Effective mask: m = ch_enable & ((1<<NUM_CH)-1). It is sampled into a register at scan start and held for the whole scan.
- FSM states: IDLE, REQ, WAIT, OUT.
- IDLE:
  - On eoc (or pending=1) with m!=0: latch mask, slot = lowest set bit, clear pending, go to REQ.
  - With m==0: eoc is ignored and no flag is set.
- REQ: single cycle; den=1, daddr=ADDRn[slot]. Go to WAIT.
- WAIT:
  - den=0, daddr holds its value.
  - On drdy: capture sample=do_in[15:4] and sample_ch=slot, go to OUT.
  - drdy in the same cycle as den (REQ) is not accepted; drdy is only sampled in WAIT.
- OUT:
  - sample_valid=1 for exactly one cycle.
  - If a higher set bit remains in the latched mask, slot = next set bit and go to REQ; otherwise go to IDLE.
- Latency: eoc at cycle 0 → den at cycle 1 → with drdy at cycle k≥2, sample_valid at cycle k+1.
- Back-to-back scans: if pending=1 when OUT finishes the last slot, the FSM goes to IDLE for one cycle, then starts the next scan.
- eoc in any non-IDLE state:
  - If pending=0, set pending=1.
  - If pending=1, set overrun=1 and drop the pulse.
- eoc in the same cycle as the final OUT counts as the busy case and sets pending.
- clear_flags together with a new overrun/timeout event in the same cycle: the set wins.
- sample and sample_ch hold their values between strobes.

Optional Feature:
- Macro: DRP_TIMEOUT_EN.
- Defined:
  - A cycle counter starts at 0 on entry to WAIT.
  - If TIMEOUT cycles elapse with no drdy: set timeout_err=1, emit no sample_valid, advance to the next slot exactly as OUT would (or go to IDLE).
  - drdy on the same cycle the counter reaches TIMEOUT is accepted as normal data.
- Undefined: WAIT has no bound, timeout_err is tied 0, and no counter logic is generated.

Test Plan:
- NUM_CH=2, ch_enable=4'b0011, eoc pulse, drdy 3 cycles after each den, do_in=16'hABC0 then 16'h1230 → den at cycle 1 with daddr=7'h13, then daddr=7'h1B; strobes give (sample=12'hABC, ch=0) then (12'h123, ch=1); busy falls after the second OUT.
- ch_enable=4'b0010 → a single read at daddr=7'h1B, sample_ch=1; ch_enable=4'b0000 → eoc produces no den and no flags.
- Two extra eoc pulses during a scan → first sets pending and a second scan starts after one IDLE cycle; second sets overrun=1; clear_flags → overrun=0.
- DRP_TIMEOUT_EN, TIMEOUT=63, drdy never asserted on slot 0 → timeout_err=1 at cycle 64 of WAIT, no strobe for ch0, slot 1 read proceeds normally.
- reset_n low while in WAIT, then drdy pulses → all outputs return to reset values; no sample_valid; next eoc starts a clean scan from slot 0.
- ch_enable changed 4'b0011→4'b0001 mid-scan → the current scan still reads both slots; the next scan reads only slot 0.
